// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with iterative MULTU/DIVU; ALU_EXEC_SIGNED_MULDIV_EN adds signed MULT/DIV
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [3:0]       i_AluCtrl,
  input  logic [WIDTH-1:0] i_AluA,
  input  logic [WIDTH-1:0] i_AluB,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_AluResult,
  output logic             o_Zero,
  output logic [WIDTH-1:0] o_Hi,
  output logic [WIDTH-1:0] o_Lo
);
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
  logic [WIDTH-1:0] opd_q, opd_d, res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] alu_res, a_mag, b_mag, div_rem, quo, rem;
  logic [WIDTH:0] mul_sum, div_try;
  logic zero_q, zero_d, negq_q, negq_d, negr_q, negr_d;
  logic sgn, is_mul, is_div, div_ge, last;
  always_comb begin
    alu_res = '0;
    case (i_AluCtrl)
      4'b0000: alu_res = i_AluA & i_AluB;
      4'b0001: alu_res = i_AluA | i_AluB;
      4'b0010: alu_res = i_AluA + i_AluB;
      4'b0011: alu_res = i_AluA ^ i_AluB;
      4'b0110: alu_res = i_AluA - i_AluB;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(i_AluA) < $signed(i_AluB)};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, i_AluA < i_AluB};
      4'b1100: alu_res = ~(i_AluA | i_AluB);
      4'b0100: alu_res = i_AluB << i_AluA[4:0];
      4'b1101: alu_res = i_AluB >> i_AluA[4:0];
      default: alu_res = '0;
    endcase
  end
  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend} for DIV
  always_comb begin
    sgn = SIGNED_EN && i_AluCtrl[3:1] == 3'b101;
    is_mul = i_AluCtrl == 4'b1000 || (SIGNED_EN && i_AluCtrl == 4'b1010);
    is_div = i_AluCtrl == 4'b1001 || (SIGNED_EN && i_AluCtrl == 4'b1011);
    a_mag = sgn && i_AluA[WIDTH-1] ? -i_AluA : i_AluA;
    b_mag = sgn && i_AluB[WIDTH-1] ? -i_AluB : i_AluB;
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opd_q : {WIDTH{1'b0}}};
    div_try = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge = div_try >= {1'b0, opd_q};
    div_rem = div_ge ? WIDTH'(div_try - {1'b0, opd_q}) : div_try[WIDTH-1:0];
    step = state_q == MUL ? {mul_sum, acc_q[WIDTH-1:1]} : {div_rem, acc_q[WIDTH-2:0], div_ge};
    prod = negq_q ? -step : step;
    quo = negq_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem = negr_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    last = cnt_q == CW'(WIDTH - 1);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opd_d = opd_q;
    res_d = res_q;
    hi_d = hi_q;
    lo_d = lo_q;
    negq_d = negq_q;
    negr_d = negr_q;
    case (state_q)
      IDLE: if (i_Start) begin
        negq_d = sgn & (i_AluA[WIDTH-1] ^ i_AluB[WIDTH-1]);
        negr_d = sgn & i_AluA[WIDTH-1];
        cnt_d = '0;
        state_d = DONE;
        if (is_mul) begin
          state_d = MUL;
          acc_d = {{WIDTH{1'b0}}, b_mag};
          opd_d = a_mag;
        end else if (is_div && i_AluB == '0) begin
          res_d = '1;
          lo_d = '1;
          hi_d = i_AluA;
        end else if (is_div) begin
          state_d = DIV;
          acc_d = {{WIDTH{1'b0}}, a_mag};
          opd_d = b_mag;
        end else res_d = alu_res;
      end
      MUL, DIV: begin
        acc_d = step;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          hi_d = state_q == MUL ? prod[2*WIDTH-1:WIDTH] : rem;
          lo_d = state_q == MUL ? prod[WIDTH-1:0] : quo;
          res_d = lo_d;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = res_d == '0;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      res_q <= '0;
      zero_q <= 1'b1;
      hi_q <= '0;
      lo_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      res_q <= res_d;
      zero_q <= zero_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
  assign o_Busy = state_q == MUL || state_q == DIV;
  assign o_Done = state_q == DONE;
  assign o_AluResult = res_q;
  assign o_Zero = zero_q;
  assign o_Hi = hi_q;
  assign o_Lo = lo_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: random and directed checks of alu_exec against an arithmetic reference model
module tb_alu_exec;
  logic i_Clk = 1'b0, i_Rst = 1'b1, i_Start = 1'b0;
  logic [3:0] i_AluCtrl = '0;
  logic [31:0] i_AluA = '0, i_AluB = '0;
  logic o_Busy, o_Done, o_Zero;
  logic [31:0] o_AluResult, o_Hi, o_Lo;
  int total = 0, bad = 0, lat, bcnt, dsaw;
  bit ck_en = 1'b0;
  typedef struct {bit multi; bit hlu; logic [31:0] r; logic [31:0] h; logic [31:0] l;} res_t;
  res_t x;
  bit m_busy = 0, m_done = 0;
  int m_rem = 0;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0, p_res, p_hi, p_lo;
  alu_exec #(.WIDTH(32)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_AluCtrl(i_AluCtrl),
    .i_AluA(i_AluA), .i_AluB(i_AluB), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_AluResult(o_AluResult), .o_Zero(o_Zero), .o_Hi(o_Hi), .o_Lo(o_Lo)
  );
  always #5 i_Clk = ~i_Clk;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endfunction
  function automatic res_t calc(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    res_t y;
    logic [63:0] p, q, r;
    longint sa, sb;
    y.multi = 0; y.hlu = 0; y.r = '0; y.h = '0; y.l = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      4'h0: y.r = a & b;
      4'h1: y.r = a | b;
      4'h2: y.r = a + b;
      4'h3: y.r = a ^ b;
      4'h6: y.r = a - b;
      4'h7: y.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h5: y.r = (a < b) ? 32'd1 : 32'd0;
      4'hC: y.r = ~(a | b);
      4'h4: y.r = b << a[4:0];
      4'hD: y.r = b >> a[4:0];
      4'h8: begin
        p = {32'b0, a} * {32'b0, b};
        y.multi = 1; y.hlu = 1; y.h = p[63:32]; y.l = p[31:0]; y.r = y.l;
      end
      4'h9: begin
        y.hlu = 1;
        if (b == 0) begin y.r = '1; y.l = '1; y.h = a; end
        else begin y.multi = 1; y.l = a / b; y.h = a % b; y.r = y.l; end
      end
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
      4'hA: begin
        p = 64'(sa * sb);
        y.multi = 1; y.hlu = 1; y.h = p[63:32]; y.l = p[31:0]; y.r = y.l;
      end
      4'hB: begin
        y.hlu = 1;
        if (b == 0) begin y.r = '1; y.l = '1; y.h = a; end
        else begin
          q = 64'(sa / sb);
          r = 64'(sa % sb);
          y.multi = 1; y.l = q[31:0]; y.h = r[31:0]; y.r = y.l;
        end
      end
`endif
      default: y.r = '0;
    endcase
    return y;
  endfunction
  always_comb x = calc(i_AluCtrl, i_AluA, i_AluB);
  always @(posedge i_Clk) begin
    if (i_Rst) begin
      m_busy <= 0; m_done <= 0; m_rem <= 0; m_res <= '0; m_hi <= '0; m_lo <= '0;
    end else if (m_done) m_done <= 0;
    else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 0; m_done <= 1; m_res <= p_res; m_hi <= p_hi; m_lo <= p_lo;
      end
    end else if (i_Start) begin
      if (x.multi) begin
        m_busy <= 1; m_rem <= 32; p_res <= x.r; p_hi <= x.h; p_lo <= x.l;
      end else begin
        m_done <= 1; m_res <= x.r;
        if (x.hlu) begin m_hi <= x.h; m_lo <= x.l; end
      end
    end
  end
  always @(negedge i_Clk) if (ck_en) begin
    chk("busy", 32'(o_Busy), 32'(m_busy));
    chk("done", 32'(o_Done), 32'(m_done));
    chk("result", o_AluResult, m_res);
    chk("zero", 32'(o_Zero), 32'(m_res == 0));
    chk("hi", o_Hi, m_hi);
    chk("lo", o_Lo, m_lo);
  end
  task automatic go(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit poke);
    @(negedge i_Clk);
    i_Start = 1; i_AluCtrl = c; i_AluA = a; i_AluB = b;
    @(negedge i_Clk);
    i_Start = 0; i_AluCtrl = 4'($urandom); i_AluA = $urandom; i_AluB = $urandom;
    lat = 1; bcnt = 0;
    while (!o_Done && lat < 40) begin
      if (o_Busy) bcnt++;
      if (poke && lat == 5) begin i_Start = 1; i_AluCtrl = 4'b0010; end
      @(negedge i_Clk);
      i_Start = 0;
      lat++;
    end
    chk("done_timeout", 32'(o_Done), 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge i_Clk);
    i_Rst = 0;
    ck_en = 1;
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_zero", 32'(o_Zero), 32'd1);
    chk("rst_res", o_AluResult, 32'd0);
    chk("rst_hilo", o_Hi | o_Lo, 32'd0);
    @(negedge i_Clk);
    i_Start = 1; i_AluCtrl = 4'b1000; i_AluA = 32'hFFFFFFFF; i_AluB = 32'h2;
    @(negedge i_Clk);
    i_Start = 0;
    repeat (9) @(negedge i_Clk);
    i_Rst = 1;
    @(negedge i_Clk);
    i_Rst = 0;
    chk("abort_busy", 32'(o_Busy), 32'd0);
    chk("abort_hi", o_Hi, 32'd0);
    chk("abort_lo", o_Lo, 32'd0);
    chk("abort_zero", 32'(o_Zero), 32'd1);
    dsaw = 0;
    repeat (40) begin @(negedge i_Clk); if (o_Done) dsaw++; end
    chk("abort_nodone", 32'(dsaw), 32'd0);
    go(4'b0110, 32'd5, 32'd5, 0);
    chk("sub_lat", 32'(lat), 32'd1);
    chk("sub_res", o_AluResult, 32'd0);
    chk("sub_zero", 32'(o_Zero), 32'd1);
    go(4'b0111, 32'hFFFFFFFF, 32'd1, 0);
    chk("slt", o_AluResult, 32'd1);
    go(4'b0101, 32'hFFFFFFFF, 32'd1, 0);
    chk("sltu", o_AluResult, 32'd0);
    go(4'b1000, 32'hFFFFFFFF, 32'h2, 1);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul_busy", 32'(bcnt), 32'd32);
    chk("mul_hi", o_Hi, 32'h1);
    chk("mul_lo", o_Lo, 32'hFFFFFFFE);
    go(4'b1001, 32'd100, 32'd7, 0);
    chk("div_lat", 32'(lat), 32'd33);
    chk("div_lo", o_Lo, 32'd14);
    chk("div_hi", o_Hi, 32'd2);
    go(4'b1001, 32'd9, 32'd0, 0);
    chk("dz_lat", 32'(lat), 32'd1);
    chk("dz_lo", o_Lo, 32'hFFFFFFFF);
    chk("dz_hi", o_Hi, 32'd9);
`ifdef ALU_EXEC_SIGNED_MULDIV_EN
    go(4'b1011, 32'hFFFFFFF9, 32'd2, 0);
    chk("sdiv_lo", o_Lo, 32'hFFFFFFFD);
    chk("sdiv_hi", o_Hi, 32'hFFFFFFFF);
    go(4'b1010, 32'hFFFFFFFD, 32'd4, 0);
    chk("smul_lat", 32'(lat), 32'd33);
    chk("smul_hi", o_Hi, 32'hFFFFFFFF);
    chk("smul_lo", o_Lo, 32'hFFFFFFF4);
    go(4'b1011, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("sdiv_min_lo", o_Lo, 32'h80000000);
    chk("sdiv_min_hi", o_Hi, 32'd0);
`else
    go(4'b1010, 32'hFFFFFFFD, 32'd4, 0);
    chk("undef_lat", 32'(lat), 32'd1);
    chk("undef_res", o_AluResult, 32'd0);
    chk("undef_zero", 32'(o_Zero), 32'd1);
    chk("undef_hi", o_Hi, 32'd9);
    chk("undef_lo", o_Lo, 32'hFFFFFFFF);
`endif
    go(4'b0100, 32'd4, 32'h1, 0);
    chk("sll", o_AluResult, 32'h10);
    go(4'b1101, 32'd31, 32'h80000000, 0);
    chk("srl", o_AluResult, 32'h1);
    go(4'b1100, 32'd0, 32'd0, 0);
    chk("nor", o_AluResult, 32'hFFFFFFFF);
    chk("nor_zero", 32'(o_Zero), 32'd0);
    repeat (4000) begin
      @(negedge i_Clk);
      i_Start = ($urandom % 3) == 0;
      i_AluCtrl = 4'($urandom);
      i_AluA = ($urandom % 4 == 0) ? 32'($urandom % 64) : $urandom;
      i_AluB = ($urandom % 8 == 0) ? 32'd0 : $urandom;
      i_Rst = ($urandom % 300) == 0;
    end
    @(negedge i_Clk);
    i_Start = 0; i_Rst = 0;
    repeat (40) @(negedge i_Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
